// File: rtl/interp_seq_pkg.sv
// Shared types, plane ids and pass lookup for the interpolator tile sequencer.
package interp_seq_pkg;

  typedef enum logic [2:0] {IDLE, FEED, DRAIN, NEXT, DONE} state_t;
  typedef enum logic [2:0] {ABC, DHN, EIP, FJQ, GKR} pass_t;
  typedef enum logic {ORIENT_ROW, ORIENT_COL} orient_t;

  localparam logic [3:0] PLANE_PIX = 4'd0;
  localparam logic [3:0] PLANE_A   = 4'd1;
  localparam logic [3:0] PLANE_B   = 4'd2;
  localparam logic [3:0] PLANE_C   = 4'd3;
  localparam logic [3:0] PLANE_D   = 4'd4;
  localparam logic [3:0] PLANE_H   = 4'd5;
  localparam logic [3:0] PLANE_N   = 4'd6;
  localparam logic [3:0] PLANE_E   = 4'd7;
  localparam logic [3:0] PLANE_I   = 4'd8;
  localparam logic [3:0] PLANE_P   = 4'd9;
  localparam logic [3:0] PLANE_F   = 4'd10;
  localparam logic [3:0] PLANE_J   = 4'd11;
  localparam logic [3:0] PLANE_Q   = 4'd12;
  localparam logic [3:0] PLANE_G   = 4'd13;
  localparam logic [3:0] PLANE_K   = 4'd14;
  localparam logic [3:0] PLANE_R   = 4'd15;

  typedef struct packed {
    logic [3:0] rdPlane;
    logic [3:0] wrBase;
    orient_t    orient;
  } pass_info_t;

  // Source plane, first result plane and walk direction of each pass.
  function automatic pass_info_t passInfo(input pass_t pass);
    case (pass)
      ABC:     return '{rdPlane: PLANE_PIX, wrBase: PLANE_A, orient: ORIENT_ROW};
      DHN:     return '{rdPlane: PLANE_PIX, wrBase: PLANE_D, orient: ORIENT_COL};
      EIP:     return '{rdPlane: PLANE_A,   wrBase: PLANE_E, orient: ORIENT_COL};
      FJQ:     return '{rdPlane: PLANE_B,   wrBase: PLANE_F, orient: ORIENT_COL};
      GKR:     return '{rdPlane: PLANE_C,   wrBase: PLANE_G, orient: ORIENT_COL};
      default: return '{rdPlane: PLANE_PIX, wrBase: PLANE_A, orient: ORIENT_ROW};
    endcase
  endfunction

  function automatic pass_t nextPass(input pass_t pass);
    case (pass)
      ABC:     return DHN;
      DHN:     return EIP;
      EIP:     return FJQ;
      FJQ:     return GKR;
      default: return ABC;
    endcase
  endfunction

endpackage

// File: rtl/interp_seq_addr_gen.sv
// Maps (orientation, line, element) to a linear pixel index within the tile.
module interp_seq_addr_gen
  import interp_seq_pkg::*;
#(
  parameter int TILE_DIM = 16,
  parameter int IDX_W    = 2 * $clog2(TILE_DIM)
) (
  input  orient_t                     orient,
  input  logic [$clog2(TILE_DIM)-1:0] line,
  input  logic [$clog2(TILE_DIM)-1:0] elem,
  output logic [IDX_W-1:0]            idx
);

  // Rows walk along the fast index, columns along the slow one.
  always_comb begin
    idx = '0;
    if (orient == ORIENT_ROW)
      idx = IDX_W'(line) * IDX_W'(TILE_DIM) + IDX_W'(elem);
    else
      idx = IDX_W'(elem) * IDX_W'(TILE_DIM) + IDX_W'(line);
  end

endmodule

// File: rtl/interp_tile_sequencer.sv
// Sequences one tile through the five interpolator passes: streams edge-padded
// lines into the 6-tap datapath and writes its three outputs back per pixel.
// Optional build macro: SEQ_SATURATE_EN clamps results to 0..255.
module interp_tile_sequencer
  import interp_seq_pkg::*;
#(
  parameter int TILE_DIM = 16,
  parameter int PREFILL  = 8,
  parameter int TAIL     = 5,
  parameter int IDX_W    = 2 * $clog2(TILE_DIM)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [3:0]       rd_plane,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [31:0]      rd_data,
  output logic [31:0]      filt_data,
  output logic             filt_valid,
  input  logic [39:0]      a_val,
  input  logic [39:0]      b_val,
  input  logic [39:0]      c_val,
  output logic             wr_en,
  output logic [3:0]       wr_plane_base,
  output logic [IDX_W-1:0] wr_idx,
  output logic [31:0]      wr_data0,
  output logic [31:0]      wr_data1,
  output logic [31:0]      wr_data2
);

  localparam int LW = $clog2(TILE_DIM);
  localparam int S  = PREFILL + TILE_DIM + TAIL;
  localparam int SW = $clog2(S);

  localparam logic [SW-1:0] S_LAST     = SW'(S - 1);
  localparam logic [SW-1:0] ELEM_FIRST = SW'(PREFILL);
  localparam logic [SW-1:0] ELEM_END   = SW'(PREFILL + TILE_DIM);
  localparam logic [SW-1:0] CAP_FIRST  = SW'(PREFILL + TAIL);
  localparam logic [LW-1:0] LINE_LAST  = LW'(TILE_DIM - 1);

  state_t            state, stateNext;
  pass_t             pass;
  logic [LW-1:0]     line;
  logic [SW-1:0]     sCnt;

  logic              st1Valid, st2Valid;
  logic [SW-1:0]     st1S, st2S;
  logic [LW-1:0]     st1Line, st2Line;
  pass_t             st1Pass, st2Pass;

  logic              filtValidQ;
  logic              capture;
  pass_info_t        rdInfo, wrInfo;
  logic [LW-1:0]     rdElem, wrElem;
  logic [IDX_W-1:0]  rdAddr, wrAddr;

  function automatic logic [31:0] toResult(input logic [39:0] v);
`ifdef SEQ_SATURATE_EN
    if (v[39])
      return 32'd0;
    else if (v[37:6] > 32'd255)
      return 32'd255;
    else
      return v[37:6];
`else
    return v[37:6];
`endif
  endfunction

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state decode.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = FEED;
      FEED:    if (sCnt == S_LAST) stateNext = DRAIN;
      DRAIN:   if (sCnt == SW'(1)) stateNext = NEXT;
      NEXT:    stateNext = (pass == GKR && line == LINE_LAST) ? DONE : FEED;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Sample, line and pass counters; the sample counter doubles as drain timer.
  always_ff @(posedge clock) begin
    if (reset) begin
      sCnt <= '0;
      line <= '0;
      pass <= ABC;
    end else begin
      case (state)
        IDLE: begin
          sCnt <= '0;
          if (start) begin
            line <= '0;
            pass <= ABC;
          end
        end
        FEED:  sCnt <= (sCnt == S_LAST) ? '0 : sCnt + SW'(1);
        DRAIN: sCnt <= sCnt + SW'(1);
        NEXT: begin
          sCnt <= '0;
          if (line == LINE_LAST) begin
            line <= '0;
            pass <= nextPass(pass);
          end else begin
            line <= line + LW'(1);
          end
        end
        default: sCnt <= '0;
      endcase
    end
  end

  // Two-stage copy of the issue context so capture lines up with tap 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      st1Valid <= 1'b0;
      st1S     <= '0;
      st1Line  <= '0;
      st1Pass  <= ABC;
      st2Valid <= 1'b0;
      st2S     <= '0;
      st2Line  <= '0;
      st2Pass  <= ABC;
    end else begin
      st1Valid <= (state == FEED);
      st1S     <= sCnt;
      st1Line  <= line;
      st1Pass  <= pass;
      st2Valid <= st1Valid;
      st2S     <= st1S;
      st2Line  <= st1Line;
      st2Pass  <= st1Pass;
    end
  end

  // Read strobe delayed by the fixed memory latency.
  always_ff @(posedge clock) begin
    if (reset) filtValidQ <= 1'b0;
    else       filtValidQ <= rd_en;
  end

  // Edge-padded element selection for the sample being issued.
  always_comb begin
    rdElem = '0;
    if (sCnt < ELEM_FIRST)
      rdElem = '0;
    else if (sCnt < ELEM_END)
      rdElem = LW'(sCnt - ELEM_FIRST);
    else
      rdElem = LINE_LAST;
  end

  assign wrElem  = LW'(st2S - CAP_FIRST);
  assign capture = st2Valid && (st2S >= CAP_FIRST);
  assign rdInfo  = passInfo(pass);
  assign wrInfo  = passInfo(st2Pass);

  interp_seq_addr_gen #(.TILE_DIM(TILE_DIM), .IDX_W(IDX_W)) u_rdAddr (
    .orient (rdInfo.orient),
    .line   (line),
    .elem   (rdElem),
    .idx    (rdAddr)
  );

  interp_seq_addr_gen #(.TILE_DIM(TILE_DIM), .IDX_W(IDX_W)) u_wrAddr (
    .orient (wrInfo.orient),
    .line   (st2Line),
    .elem   (wrElem),
    .idx    (wrAddr)
  );

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign rd_en         = (state == FEED);
  assign rd_plane      = rd_en ? rdInfo.rdPlane : '0;
  assign rd_idx        = rd_en ? rdAddr : '0;
  assign filt_valid    = filtValidQ;
  assign filt_data     = filtValidQ ? rd_data : '0;
  assign wr_en         = capture;
  assign wr_plane_base = capture ? wrInfo.wrBase : '0;
  assign wr_idx        = capture ? wrAddr : '0;
  assign wr_data0      = capture ? toResult(a_val) : '0;
  assign wr_data1      = capture ? toResult(b_val) : '0;
  assign wr_data2      = capture ? toResult(c_val) : '0;

endmodule

// File: tb/tb_interp_tile_sequencer.sv
// Self-checking bench: plane memory, behavioural 6-tap interpolator and a
// pass-by-pass reference model of the whole tile computed from plain loops.
module tb_interp_tile_sequencer;

  localparam int TD = 16;
  localparam int PF = 8;
  localparam int TL = 5;
  localparam int S  = PF + TD + TL;
  localparam int IW = 8;
  localparam int LAT = 1 + 5 * TD * (S + 3);

  logic          clock = 1'b0;
  logic          reset, start;
  logic          busy, done, rd_en, filt_valid, wr_en;
  logic [3:0]    rd_plane, wr_plane_base;
  logic [IW-1:0] rd_idx, wr_idx;
  logic [31:0]   rd_data, filt_data, wr_data0, wr_data1, wr_data2;
  logic [39:0]   aVal, bVal, cVal;

  logic [31:0]   mem [16][256];
  logic [31:0]   modelMem [16][256];
  logic [31:0]   tap [6];
  logic          forceA = 1'b0;
  logic [39:0]   forceVal = '0;
  int            cyc = 0;
  int            t0;
  int            checks = 0;
  int            errors = 0;

  typedef struct packed {logic [3:0] plane; logic [7:0] idx;} rd_t;
  typedef struct packed {logic [3:0] plane; logic [7:0] idx; logic [31:0] d0, d1, d2;} wr_t;

  rd_t         dutRd[$], expRd[$];
  wr_t         dutWr[$], expWr[$];
  logic [31:0] dutFilt[$], expFilt[$];

  interp_tile_sequencer #(.TILE_DIM(TD), .PREFILL(PF), .TAIL(TL), .IDX_W(IW)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .rd_en         (rd_en),
    .rd_plane      (rd_plane),
    .rd_idx        (rd_idx),
    .rd_data       (rd_data),
    .filt_data     (filt_data),
    .filt_valid    (filt_valid),
    .a_val         (aVal),
    .b_val         (bVal),
    .c_val         (cVal),
    .wr_en         (wr_en),
    .wr_plane_base (wr_plane_base),
    .wr_idx        (wr_idx),
    .wr_data0      (wr_data0),
    .wr_data1      (wr_data1),
    .wr_data2      (wr_data2)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Plane memory: 1-cycle read, garbage when not strobed; three-plane write.
  always @(posedge clock) begin
    if (rd_en) rd_data <= mem[rd_plane][rd_idx];
    else       rd_data <= $urandom;
    if (wr_en) begin
      mem[wr_plane_base][wr_idx]        <= wr_data0;
      mem[wr_plane_base + 4'd1][wr_idx] <= wr_data1;
      mem[wr_plane_base + 4'd2][wr_idx] <= wr_data2;
    end
  end

  // Behavioural interpolator: registered data_in followed by a 6-deep shift.
  always @(posedge clock) begin
    tap[0] <= filt_data;
    for (int k = 1; k < 6; k++) tap[k] <= tap[k-1];
  end

  assign aVal = forceA ? forceVal : ((40'(tap[0]) + 40'(tap[5])) << 6);
  assign bVal = (40'(tap[1]) + 40'(tap[4])) << 6;
  assign cVal = (40'(tap[2]) + 40'(tap[3])) << 6;

  // Transaction logger.
  always @(negedge clock) begin
    if (rd_en)      dutRd.push_back({rd_plane, rd_idx});
    if (wr_en)      dutWr.push_back({wr_plane_base, wr_idx, wr_data0, wr_data1, wr_data2});
    if (filt_valid) dutFilt.push_back(filt_data);
  end

  function automatic logic [31:0] expConv(input logic [39:0] v);
    logic [31:0] mid;
    mid = 32'(v >> 6);
`ifdef SEQ_SATURATE_EN
    if (v[39]) return 32'd0;
    if (mid > 32'd255) return 32'd255;
`endif
    return mid;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic buildModel();
    int rdTab [5]  = '{0, 0, 1, 2, 3};
    int wrTab [5]  = '{1, 4, 7, 10, 13};
    bit colTab [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] x [S];
    int e, idx, s;
    logic [39:0] a, b, c;
    for (int p = 0; p < 16; p++)
      for (int i = 0; i < 256; i++)
        modelMem[p][i] = (p == 0) ? mem[0][i] : 32'd0;
    for (int ps = 0; ps < 5; ps++)
      for (int ln = 0; ln < TD; ln++) begin
        for (int k = 0; k < S; k++) begin
          e   = (k < PF) ? 0 : (k < PF + TD) ? k - PF : TD - 1;
          idx = colTab[ps] ? e * TD + ln : ln * TD + e;
          x[k] = modelMem[rdTab[ps]][idx];
          expRd.push_back(rd_t'{4'(rdTab[ps]), 8'(idx)});
          expFilt.push_back(x[k]);
        end
        for (int p = 0; p < TD; p++) begin
          s   = p + PF + TL;
          a   = (40'(x[s])   + 40'(x[s-5])) << 6;
          b   = (40'(x[s-1]) + 40'(x[s-4])) << 6;
          c   = (40'(x[s-2]) + 40'(x[s-3])) << 6;
          idx = colTab[ps] ? p * TD + ln : ln * TD + p;
          modelMem[wrTab[ps]][idx]     = expConv(a);
          modelMem[wrTab[ps] + 1][idx] = expConv(b);
          modelMem[wrTab[ps] + 2][idx] = expConv(c);
          expWr.push_back(wr_t'{4'(wrTab[ps]), 8'(idx), expConv(a), expConv(b), expConv(c)});
        end
      end
  endtask

  task automatic clearLogs();
    dutRd.delete();
    dutWr.delete();
    dutFilt.delete();
  endtask

  task automatic compareLogs(input string tag);
    int n;
    check({tag, "_rd_count"}, dutRd.size(), expRd.size());
    check({tag, "_wr_count"}, dutWr.size(), expWr.size());
    check({tag, "_filt_count"}, dutFilt.size(), expFilt.size());
    n = (dutRd.size() < expRd.size()) ? dutRd.size() : expRd.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_rd[%0d]", tag, i), dutRd[i], expRd[i]);
    n = (dutWr.size() < expWr.size()) ? dutWr.size() : expWr.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_wr[%0d]", tag, i), dutWr[i], expWr[i]);
    n = (dutFilt.size() < expFilt.size()) ? dutFilt.size() : expFilt.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_filt[%0d]", tag, i), dutFilt[i], expFilt[i]);
    if (dutWr.size() > 0) begin
      check({tag, "_first_wr"}, {dutWr[0].plane, dutWr[0].idx}, {4'd1, 8'd0});
      check({tag, "_last_wr"}, {dutWr[$].plane, dutWr[$].idx}, {4'd13, 8'd255});
    end
  endtask

  task automatic startTile();
    @(negedge clock);
    start = 1'b1;
    t0 = cyc;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic waitDone(input bit holdEnd);
    bit seen = 1'b0;
    int rel = 0;
    for (int n = 0; n < LAT + 200 && !seen; n++) begin
      @(negedge clock);
      rel = cyc - t0;
      if (!filt_valid) check("filt_idle_zero", filt_data, 32'd0);
      if (done) begin
        seen = 1'b1;
        check("busy_in_done", busy, 1'b1);
      end else if (holdEnd && rel >= LAT - 2) begin
        start = 1'b1;
      end else begin
        start = ((rel % 397) == 5);
      end
    end
    check("done_seen", seen, 1'b1);
    check("done_latency", rel, LAT);
  endtask

  initial begin
    logic [39:0] satVals [4];
    bit gotWr;
    int n;
    reset = 1'b1;
    start = 1'b0;
    for (int p = 0; p < 16; p++)
      for (int i = 0; i < 256; i++)
        mem[p][i] = (p == 0) ? 32'($urandom_range(0, 1023)) : 32'd0;
    buildModel();

    // Reset state.
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_rd_addr", {rd_plane, rd_idx}, 12'd0);
    check("rst_filt", {filt_valid, filt_data}, 33'd0);
    check("rst_wr", {wr_en, wr_plane_base, wr_idx, wr_data0}, 45'd0);
    reset = 1'b0;

    // Full tile with stray start pulses; start held high into DONE.
    clearLogs();
    startTile();
    waitDone(1'b1);
    compareLogs("tile1");
    @(negedge clock);
    check("idle_after_done_busy", busy, 1'b0);
    check("done_one_pulse", done, 1'b0);
    t0 = cyc;
    clearLogs();
    @(negedge clock);
    start = 1'b0;
    check("restart_from_idle", busy, 1'b1);
    waitDone(1'b0);
    compareLogs("tile2");
    @(negedge clock);
    check("idle_after_tile2", busy, 1'b0);

    // Abort mid-FEED of DHN line 3 (sample 10, element 2).
    startTile();
    for (int k = 0; k < 1000 && (cyc - t0) < 1 + (TD + 3) * (S + 3) + 10; k++) @(negedge clock);
    check("dhn_l3_rd", {rd_en, rd_plane, rd_idx}, {1'b1, 4'd0, 8'd35});
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n = dutWr.size();
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_rd_en", rd_en, 1'b0);
    check("abort_wr_en", wr_en, 1'b0);
    repeat (40) @(negedge clock);
    check("abort_no_writes", dutWr.size(), n);
    clearLogs();
    startTile();
    waitDone(1'b0);
    compareLogs("tile3");

    // Result conversion with a forced a_val on the first capture of a tile.
    satVals[0] = 40'hFF_FFFF_FFC0;
    satVals[1] = 40'd300 << 6;
    satVals[2] = 40'd100 << 6;
    satVals[3] = {8'h00, 32'($urandom)} << 6;
    for (int v = 0; v < 4; v++) begin
      forceA   = 1'b1;
      forceVal = satVals[v];
      startTile();
      gotWr = 1'b0;
      for (int k = 0; k < 100 && !gotWr; k++) begin
        @(negedge clock);
        gotWr = wr_en;
      end
      check($sformatf("sat%0d_seen", v), gotWr, 1'b1);
      check($sformatf("sat%0d_first_cycle", v), cyc - t0, 16);
      check($sformatf("sat%0d_addr", v), {wr_plane_base, wr_idx}, {4'd1, 8'd0});
      check($sformatf("sat%0d_data0", v), wr_data0, expConv(satVals[v]));
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
    end
    forceA = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
